// File: rtl/frame_align_ctrl_if.sv
// frame_align_ctrl_if: control/status and ISERDES-facing signals of one channel's
// word-alignment sequencer.
//   start   : one-cycle (re)train request from slow control
//   frame   : 6-bit deserialized frame-line word, CLK-timed
//   bs      : bitslip pulse fanned out to every ISERDES of the channel
//   busy    : training in progress
//   locked  : alignment achieved and holding
//   error   : training gave up after the slip budget was exhausted
//   lost    : sticky, lock was lost at least once since the last start
//   slipcnt : slips issued in the current training run
// master = register block / ISERDES side, slave = the sequencer.
`timescale 1ns / 1ps

interface frame_align_ctrl_if;
    logic       start;
    logic [5:0] frame;
    logic       bs;
    logic       busy;
    logic       locked;
    logic       error;
    logic       lost;
    logic [3:0] slipcnt;

    modport master (
        output start, frame,
        input  bs, busy, locked, error, lost, slipcnt
    );

    modport slave (
        input  start, frame,
        output bs, busy, locked, error, lost, slipcnt
    );
endinterface

// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: per-channel bitslip training sequencer for ADC word alignment.
// Waits a settle period, checks the frame line against FramePat, slips once per
// mismatch until Stable consecutive matches are seen, then supervises the lock and
// retrains on its own after Loss consecutive mismatches.
//   clk_i  : divided ADC clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : frame_align_ctrl_if.slave (start/frame in, bs and status out)
// All outputs come straight from flops.
`timescale 1ns / 1ps

module frame_align_ctrl #(
    parameter logic [5:0]  FramePat = 6'b111000,
    parameter int unsigned Settle   = 16,
    parameter int unsigned Stable   = 64,
    parameter int unsigned MaxSlip  = 11,
    parameter int unsigned Loss     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    frame_align_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCheck,
        StSlip,
        StLocked,
        StFail
    } state_e;

    localparam logic [7:0] SettleLoad = 8'(Settle - 1);
    localparam logic [7:0] StableLast = 8'(Stable - 1);
    localparam logic [3:0] MaxSlipCnt = 4'(MaxSlip);
    localparam logic [3:0] LossLast   = 4'(Loss - 1);

    state_e     state_q, state_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [3:0] loss_cnt_q, loss_cnt_d;
    logic [3:0] slip_cnt_q, slip_cnt_d;
    logic       lost_q, lost_d;
    logic       bs_q, bs_d;
    logic       busy_q, busy_d;
    logic       locked_q, locked_d;
    logic       error_q, error_d;
    logic       frame_ok;

    assign frame_ok = (bus.frame == FramePat);

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            slip_cnt_q   <= '0;
            lost_q       <= 1'b0;
            bs_q         <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            lost_q       <= lost_d;
            bs_q         <= bs_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
        end
    end

    // Next state and counters; start overrides every other transition
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        lost_d       = lost_q;
        if (bus.start) begin
            state_d      = StSettle;
            settle_cnt_d = SettleLoad;
            slip_cnt_d   = '0;
            lost_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StSettle: begin
                    if (settle_cnt_q == '0) begin
                        state_d     = StCheck;
                        match_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 8'd1;
                    end
                end
                StCheck: begin
                    if (frame_ok) begin
                        if (match_cnt_q == StableLast) begin
                            state_d    = StLocked;
                            loss_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                    end else if (slip_cnt_q >= MaxSlipCnt) begin
                        state_d = StFail;
                    end else begin
                        // Count on entry to SLIP so SLIPCNT moves together with BS
                        state_d    = StSlip;
                        slip_cnt_d = (slip_cnt_q == 4'hf) ? slip_cnt_q : slip_cnt_q + 4'd1;
                    end
                end
                StSlip: begin
                    state_d      = StSettle;
                    settle_cnt_d = SettleLoad;
                end
                StLocked: begin
                    if (frame_ok) begin
                        loss_cnt_d = '0;
                    end else if (loss_cnt_q == LossLast) begin
                        state_d      = StSettle;
                        settle_cnt_d = SettleLoad;
                        slip_cnt_d   = '0;
                        loss_cnt_d   = '0;
                        lost_d       = 1'b1;
                    end else begin
                        loss_cnt_d = loss_cnt_q + 4'd1;
                    end
                end
                StFail: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decoded from the next state so they are registered alongside it
    always_comb begin
        bs_d     = (state_d == StSlip);
        busy_d   = (state_d == StSettle) || (state_d == StCheck) || (state_d == StSlip);
        locked_d = (state_d == StLocked);
        error_d  = (state_d == StFail);
    end

    assign bus.bs      = bs_q;
    assign bus.busy    = busy_q;
    assign bus.locked  = locked_q;
    assign bus.error   = error_q;
    assign bus.lost    = lost_q;
    assign bus.slipcnt = slip_cnt_q;

endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb_frame_align_ctrl: directed self-checking bench for frame_align_ctrl with
// default parameters (Settle 16, Stable 64, MaxSlip 11, Loss 4).
`timescale 1ns / 1ps

module tb_frame_align_ctrl;

    localparam logic [5:0] Pat = 6'b111000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   bs_total = 0;
    int   last_bs = -1000;
    int   min_gap = 1000;

    frame_align_ctrl_if bus();

    frame_align_ctrl u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Count BS pulses and the smallest spacing between them
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.bs === 1'b1) begin
            bs_total <= bs_total + 1;
            last_bs  <= cyc;
            if (cyc - last_bs < min_gap) min_gap <= cyc - last_bs;
        end
    end

    function automatic logic [5:0] rotl(input logic [5:0] w, input int k);
        logic [5:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[4:0], r[5]};
        return r;
    endfunction

    function automatic logic [8:0] status();
        return {bus.bs, bus.busy, bus.locked, bus.error, bus.lost, bus.slipcnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.frame = Pat;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (status() !== 9'd0) begin
            errors++;
            $display("FAIL reset_status: got %b want %b", status(), 9'd0);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (status() !== 9'd0) begin
            errors++;
            $display("FAIL idle_no_start: got %b want %b", status(), 9'd0);
        end
    endtask

    task automatic test_lock_direct();
        int b0;
        b0 = bs_total;
        bus.frame = Pat;
        pulse_start();
        checks++;
        if ({bus.bs, bus.busy, bus.locked, bus.error} !== 4'b0100) begin
            errors++;
            $display("FAIL direct_busy_after_start: got %b want %b",
                     {bus.bs, bus.busy, bus.locked, bus.error}, 4'b0100);
        end
        repeat (79) tick();
        checks++;
        if ({bus.busy, bus.locked} !== 2'b10) begin
            errors++;
            $display("FAIL direct_edge79: got busy,locked=%b want 10", {bus.busy, bus.locked});
        end
        tick();
        checks++;
        if ({bus.busy, bus.locked, bus.slipcnt} !== 6'b01_0000) begin
            errors++;
            $display("FAIL direct_edge80: got busy,locked,slipcnt=%b want 010000",
                     {bus.busy, bus.locked, bus.slipcnt});
        end
        checks++;
        if (bs_total - b0 !== 0) begin
            errors++;
            $display("FAIL direct_bs_count: got %0d want 0", bs_total - b0);
        end
    endtask

    task automatic test_rotate();
        int b0;
        int n;
        int ofs;
        b0 = bs_total;
        ofs = 3;
        bus.frame = rotl(Pat, ofs);
        pulse_start();
        n = 0;
        while (bus.locked !== 1'b1 && n < 2000) begin
            if (bus.bs === 1'b1) begin
                ofs = (ofs + 5) % 6;
                bus.frame = rotl(Pat, ofs);
            end
            tick();
            n++;
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL rotate_lock_timeout: got locked=%b want 1", bus.locked);
        end
        checks++;
        if (bs_total - b0 !== 3) begin
            errors++;
            $display("FAIL rotate_bs_count: got %0d want 3", bs_total - b0);
        end
        checks++;
        if (min_gap < 18) begin
            errors++;
            $display("FAIL rotate_bs_spacing: got %0d want >= 18", min_gap);
        end
        checks++;
        if (bus.slipcnt !== 4'd3) begin
            errors++;
            $display("FAIL rotate_slipcnt: got %0d want 3", bus.slipcnt);
        end
    endtask

    task automatic test_fail();
        int b0;
        int n;
        b0 = bs_total;
        bus.frame = 6'b000000;
        pulse_start();
        n = 0;
        while (bus.error !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if ({bus.error, bus.busy, bus.locked} !== 3'b100) begin
            errors++;
            $display("FAIL fail_status: got error,busy,locked=%b want 100",
                     {bus.error, bus.busy, bus.locked});
        end
        checks++;
        if (bs_total - b0 !== 11) begin
            errors++;
            $display("FAIL fail_bs_count: got %0d want 11", bs_total - b0);
        end
        checks++;
        if (bus.slipcnt !== 4'd11) begin
            errors++;
            $display("FAIL fail_slipcnt: got %0d want 11", bus.slipcnt);
        end
        repeat (10) tick();
        pulse_start();
        checks++;
        if ({bus.error, bus.busy, bus.slipcnt} !== 6'b01_0000) begin
            errors++;
            $display("FAIL fail_restart: got error,busy,slipcnt=%b want 010000",
                     {bus.error, bus.busy, bus.slipcnt});
        end
    endtask

    task automatic test_loss();
        int n;
        bus.frame = Pat;
        pulse_start();
        n = 0;
        while (bus.locked !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL loss_initial_lock: got locked=%b want 1", bus.locked);
        end
        bus.frame = 6'b000000;
        repeat (3) tick();
        checks++;
        if ({bus.locked, bus.lost} !== 2'b10) begin
            errors++;
            $display("FAIL loss_burst3: got locked,lost=%b want 10", {bus.locked, bus.lost});
        end
        bus.frame = Pat;
        tick();
        bus.frame = 6'b000000;
        repeat (3) tick();
        checks++;
        if ({bus.locked, bus.lost} !== 2'b10) begin
            errors++;
            $display("FAIL loss_counter_cleared: got locked,lost=%b want 10",
                     {bus.locked, bus.lost});
        end
        tick();
        checks++;
        if ({bus.locked, bus.busy, bus.lost} !== 3'b011) begin
            errors++;
            $display("FAIL loss_fourth: got locked,busy,lost=%b want 011",
                     {bus.locked, bus.busy, bus.lost});
        end
        bus.frame = Pat;
        repeat (79) tick();
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL loss_relock_early: got locked=%b want 0", bus.locked);
        end
        tick();
        checks++;
        if ({bus.locked, bus.lost, bus.slipcnt} !== 6'b11_0000) begin
            errors++;
            $display("FAIL loss_relock: got locked,lost,slipcnt=%b want 110000",
                     {bus.locked, bus.lost, bus.slipcnt});
        end
    endtask

    task automatic test_start_in_check();
        int b0;
        bus.frame = 6'b000000;
        pulse_start();
        repeat (16) tick();
        b0 = bs_total;
        // First compare (a mismatch) is sampled on the same edge as this start
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.bs, bus.busy, bus.slipcnt} !== 6'b01_0000) begin
            errors++;
            $display("FAIL start_in_check: got bs,busy,slipcnt=%b want 010000",
                     {bus.bs, bus.busy, bus.slipcnt});
        end
        repeat (16) tick();
        checks++;
        if (bus.bs !== 1'b0 || bs_total - b0 !== 0) begin
            errors++;
            $display("FAIL start_in_check_no_bs: got bs=%b pulses=%0d want 0 0",
                     bus.bs, bs_total - b0);
        end
        tick();
        checks++;
        if ({bus.bs, bus.slipcnt} !== 5'b1_0001) begin
            errors++;
            $display("FAIL start_in_check_resettle: got bs,slipcnt=%b want 10001",
                     {bus.bs, bus.slipcnt});
        end
    endtask

    task automatic test_reset_mid();
        // Entered with BS high (SLIP state)
        rst_n = 1'b0;
        #1;
        checks++;
        if (status() !== 9'd0) begin
            errors++;
            $display("FAIL reset_in_slip: got %b want %b", status(), 9'd0);
        end
        #2;
        rst_n = 1'b1;
        bus.frame = Pat;
        repeat (30) tick();
        checks++;
        if (status() !== 9'd0) begin
            errors++;
            $display("FAIL idle_after_slip_reset: got %b want %b", status(), 9'd0);
        end
        pulse_start();
        repeat (80) tick();
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_before_reset: got locked=%b want 1", bus.locked);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (status() !== 9'd0) begin
            errors++;
            $display("FAIL reset_in_locked: got %b want %b", status(), 9'd0);
        end
        #2;
        rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (status() !== 9'd0) begin
            errors++;
            $display("FAIL idle_after_locked_reset: got %b want %b", status(), 9'd0);
        end
    endtask

    initial begin
        test_reset();
        test_lock_direct();
        test_rotate();
        test_fail();
        test_loss();
        test_start_in_check();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
